// File: rtl/lc3_mem_pkg.sv
// Shared types and default widths for the LC-3 memory port and its write buffer.
package lc3_mem_pkg;

  localparam int LC3_DATA_W = 16;
  localparam int LC3_ADDR_W = 16;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } port_state_t;

  typedef struct packed {
    logic [LC3_ADDR_W-1:0] addr;
    logic [LC3_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/lc3_wbuf.sv
// Circular write buffer with a parallel address search that returns the youngest matching entry.
module lc3_wbuf
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = LC3_DATA_W,
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] search_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   idx;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count != '0);

  assign head_addr = entries[rd_ptr].addr;
  assign head_data = entries[rd_ptr].data;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entries[wr_ptr].addr <= push_addr;
      entries[wr_ptr].data <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (the youngest write) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == search_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/lc3_mem_port.sv
// LC-3 core-to-memory port: posted writes through a write buffer, reads forwarded from the
// buffer on a hit or fetched from a fixed-latency memory on a miss.
module lc3_mem_port
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W     = LC3_DATA_W,
  parameter int ADDR_W     = LC3_ADDR_W,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LAT     = 2,
  localparam int CNT_W     = $clog2(WBUF_DEPTH + 1),
  localparam int LAT_W     = $clog2(RD_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic [CNT_W-1:0]  wbuf_count
);

  port_state_t        state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               wb_hit;
  logic               wb_full;
  logic [DATA_W-1:0]  wb_hit_data;
  logic [ADDR_W-1:0]  wb_head_addr;
  logic [DATA_W-1:0]  wb_head_data;
  logic [CNT_W-1:0]   wb_count;

  logic               rd_req;
  logic               wr_req;
  logic               rd_ready;
  logic               rd_accept;
  logic               rd_miss;
  logic               wr_accept;
  logic               drain;

  lc3_wbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (wr_accept),
    .push_addr   (cpu_addr),
    .push_data   (cpu_wdata),
    .pop         (drain),
    .head_addr   (wb_head_addr),
    .head_data   (wb_head_data),
    .search_addr (cpu_addr),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data),
    .count       (wb_count),
    .full        (wb_full)
  );

  // A read miss owns the memory port in its accept cycle; the drain takes whatever is left.
  assign rd_req    = cpu_req & ~cpu_we;
  assign wr_req    = cpu_req & cpu_we;
  assign rd_ready  = (state_q == IDLE) & (wb_hit | ~mem_stall);
  assign cpu_ready = rst & (cpu_we ? ~wb_full : rd_ready);
  assign rd_accept = rst & rd_req & rd_ready;
  assign rd_miss   = rd_accept & ~wb_hit;
  assign wr_accept = rst & wr_req & ~wb_full;
  assign drain     = rst & (wb_count != '0) & ~mem_stall & ~rd_miss;

  assign mem_re    = rd_miss;
  assign mem_we    = drain;
  assign mem_addr  = rd_miss ? cpu_addr : wb_head_addr;
  assign mem_wdata = wb_head_data;

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign wbuf_count = wb_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Hits complete in one cycle from IDLE; misses count down RD_LAT cycles in RD_WAIT.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_accept && wb_hit) begin
          rvalid_d = 1'b1;
          rdata_d  = wb_hit_data;
        end else if (rd_miss) begin
          state_d = RD_WAIT;
          lat_d   = LAT_W'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assert property (@(posedge clk) disable iff (!rst) !(mem_we && mem_re));

endmodule

// File: tb/tb_lc3_mem_port.sv
// Self-checking bench for lc3_mem_port: directed scenarios plus a randomized run against a
// queue-based reference model of the buffer, memory and read timing.
module tb_lc3_mem_port;
  import lc3_mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_stall = 1'b0;
  logic [2:0]  wbuf_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lc3_mem_port #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .WBUF_DEPTH (DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_stall  (mem_stall),
    .wbuf_count (wbuf_count)
  );

  // Unwritten locations read as a fixed function of the address (0x4000 reads 0x1234).
  function automatic logic [15:0] mem_default(input logic [15:0] a);
    return a ^ 16'h5234;
  endfunction

  logic [15:0] env_mem [65536];
  logic        env_wr  [65536];
  logic [15:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_wr[mem_addr]  <= 1'b1;
    end
    rd_pipe[0] <= mem_re ? ((env_wr[mem_addr] === 1'b1) ? env_mem[mem_addr] : mem_default(mem_addr))
                         : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic drive(input logic req, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic stall);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_stall = stall;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'h1000, 16'h1111, 1'b0);
    #1;
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL por_ready got=%0h want=0", cpu_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL por_mem_we got=%0h want=0", mem_we); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("[TB] FAIL por_mem_re got=%0h want=0", mem_re); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL por_rvalid got=%0h want=0", cpu_rvalid); end
    total++; if (cpu_rdata !== 16'h0) begin bad++; $display("[TB] FAIL por_rdata got=%0h want=0", cpu_rdata); end
    total++; if (wbuf_count !== 3'd0) begin bad++; $display("[TB] FAIL por_count got=%0d want=0", wbuf_count); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h1000, 16'h1111, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h1001, 16'h2222, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h2000, 16'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h1002, 16'h3333, 1'b1);
    #2 rst = 1'b0;
    #1;
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready got=%0h want=0", cpu_ready); end
    total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("[TB] FAIL mid_mem got=%0h%0h want=00", mem_we, mem_re); end
    total++; if (wbuf_count !== 3'd0) begin bad++; $display("[TB] FAIL mid_count got=%0d want=0", wbuf_count); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rvalid got=%0h want=0", cpu_rvalid); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h1003, 16'h4444, 1'b1);
    #1;
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_ready got=%0h want=1", cpu_ready); end
    total++; if (wbuf_count !== 3'd0) begin bad++; $display("[TB] FAIL rel_count got=%0d want=0", wbuf_count); end
    @(negedge clk);
  endtask

  task automatic test_wbuf_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 16'h3000 + 16'(i), 16'hC000 + 16'(i), 1'b1);
      #1;
      total++; if (cpu_ready !== (i < 4)) begin bad++; $display("[TB] FAIL full_ready%0d got=%0h want=%0h", i, cpu_ready, (i < 4)); end
      @(negedge clk);
    end
    #1;
    total++; if (wbuf_count !== 3'd4) begin bad++; $display("[TB] FAIL full_count got=%0d want=4", wbuf_count); end
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b1, 16'h3004, 16'hC004, 1'b0);
      #1;
      if (i == 0) begin
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_drain_ready got=%0h want=0", cpu_ready); end
      end
      total++; if (mem_we !== 1'b1 || mem_addr !== 16'h3000 + 16'(i) || mem_wdata !== 16'hC000 + 16'(i)) begin
        bad++; $display("[TB] FAIL drain%0d got=we%0h %h=%h want=we1 %h=%h", i, mem_we, mem_addr, mem_wdata,
                        16'h3000 + 16'(i), 16'hC000 + 16'(i));
      end
      @(negedge clk);
    end
    #1;
    total++; if (mem_we !== 1'b0 || wbuf_count !== 3'd0) begin bad++; $display("[TB] FAIL drain_end got=we%0h cnt%0d want=we0 cnt0", mem_we, wbuf_count); end
    @(negedge clk);
  endtask

  task automatic test_forward();
    do_reset();
    drive(1'b1, 1'b1, 16'h3000, 16'hAAAA, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h3000, 16'hBBBB, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h3000, 16'h0, 1'b1);
    #1;
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL fwd_ready got=%0h want=1", cpu_ready); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("[TB] FAIL fwd_mem_re got=%0h want=0", mem_re); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBBBB) begin bad++; $display("[TB] FAIL fwd_data got=v%0h %h want=v1 bbbb", cpu_rvalid, cpu_rdata); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("[TB] FAIL fwd_mem_re2 got=%0h want=0", mem_re); end
    @(negedge clk);
    #1;
    total++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBBBB) begin bad++; $display("[TB] FAIL fwd_hold got=v%0h %h want=v0 bbbb", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    do_reset();
    drive(1'b1, 1'b0, 16'h4000, 16'h0, 1'b0);
    #1;
    total++; if (cpu_ready !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL miss_issue got=rdy%0h re%0h we%0h want=rdy1 re1 we0", cpu_ready, mem_re, mem_we); end
    total++; if (mem_addr !== 16'h4000) begin bad++; $display("[TB] FAIL miss_addr got=%h want=4000", mem_addr); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h4002, 16'h0, 1'b1);
    #1;
    total++; if (cpu_ready !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("[TB] FAIL miss_busy got=rdy%0h re%0h want=rdy0 re0", cpu_ready, mem_re); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL miss_early1 got=%0h want=0", cpu_rvalid); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL miss_early2 got=%0h want=0", cpu_rvalid); end
    @(negedge clk);
    #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin bad++; $display("[TB] FAIL miss_data got=v%0h %h want=v1 1234", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_drain_priority();
    do_reset();
    drive(1'b1, 1'b1, 16'h5000, 16'h0A0A, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h5001, 16'h0B0B, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h6000, 16'h0, 1'b0);
    #1;
    total++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h6000) begin bad++; $display("[TB] FAIL prio_issue got=re%0h we%0h %h want=re1 we0 6000", mem_re, mem_we, mem_addr); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 16'h5000 || mem_wdata !== 16'h0A0A) begin bad++; $display("[TB] FAIL prio_drain0 got=we%0h %h=%h want=we1 5000=0a0a", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 16'h5001 || mem_wdata !== 16'h0B0B) begin bad++; $display("[TB] FAIL prio_drain1 got=we%0h %h=%h want=we1 5001=0b0b", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL prio_idle got=%0h want=0", mem_we); end
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_default(16'h6000)) begin bad++; $display("[TB] FAIL prio_data got=v%0h %h want=v1 %h", cpu_rvalid, cpu_rdata, mem_default(16'h6000)); end
    @(negedge clk);
  endtask

  task automatic test_reset_rd_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h5100 + 16'(i), 16'h7700 + 16'(i), 1'b1);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 16'h6100, 16'h0, 1'b0);
    #1;
    total++; if (mem_re !== 1'b1) begin bad++; $display("[TB] FAIL rw_issue got=%0h want=1", mem_re); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    total++; if (wbuf_count !== 3'd3) begin bad++; $display("[TB] FAIL rw_count got=%0d want=3", wbuf_count); end
    #2 rst = 1'b0;
    #1;
    total++; if (wbuf_count !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rw_reset got=cnt%0d we%0h want=cnt0 we0", wbuf_count, mem_we); end
    @(negedge clk);
    rst = 1'b1;
    mem_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (cpu_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || wbuf_count !== 3'd0) begin
        bad++; $display("[TB] FAIL rw_after%0d got=v%0h we%0h re%0h cnt%0d want=all 0", i, cpu_rvalid, mem_we, mem_re, wbuf_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    wbuf_entry_t wq[$];
    wbuf_entry_t e;
    logic [15:0] ref_mem [logic [15:0]];
    int          cyc;
    int          rv_at;
    int          busy_until;
    logic [15:0] exp_rdata;
    logic        req, we, stall, hit, exp_ready, exp_re, exp_we;
    logic [15:0] a, d, hdata;
    cyc = 0;
    rv_at = -1;
    busy_until = 0;
    exp_rdata = '0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req   = ($urandom_range(0, 9) < 7);
      we    = 1'($urandom_range(0, 1));
      a     = 16'h7000 + 16'($urandom_range(0, 5));
      d     = 16'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      drive(req, we, a, d, stall);
      #1;
      hit = 1'b0;
      hdata = '0;
      foreach (wq[i]) if (wq[i].addr == a) begin hit = 1'b1; hdata = wq[i].data; end
      exp_ready = we ? (wq.size() < DEPTH) : ((cyc >= busy_until) && (hit || !stall));
      exp_re    = req && !we && exp_ready && !hit;
      exp_we    = (wq.size() > 0) && !stall && !exp_re;
      if (req) begin
        total++; if (cpu_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready c%0d got=%0h want=%0h", cyc, cpu_ready, exp_ready); end
      end
      total++; if (mem_re !== exp_re) begin bad++; $display("[TB] FAIL rnd_mem_re c%0d got=%0h want=%0h", cyc, mem_re, exp_re); end
      total++; if (mem_we !== exp_we) begin bad++; $display("[TB] FAIL rnd_mem_we c%0d got=%0h want=%0h", cyc, mem_we, exp_we); end
      if (exp_re) begin
        total++; if (mem_addr !== a) begin bad++; $display("[TB] FAIL rnd_re_addr c%0d got=%h want=%h", cyc, mem_addr, a); end
      end
      if (exp_we) begin
        total++; if (mem_addr !== wq[0].addr || mem_wdata !== wq[0].data) begin
          bad++; $display("[TB] FAIL rnd_drain c%0d got=%h=%h want=%h=%h", cyc, mem_addr, mem_wdata, wq[0].addr, wq[0].data);
        end
      end
      total++; if (cpu_rvalid !== (cyc == rv_at)) begin bad++; $display("[TB] FAIL rnd_rvalid c%0d got=%0h want=%0h", cyc, cpu_rvalid, (cyc == rv_at)); end
      if (cyc == rv_at) begin
        total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rnd_rdata c%0d got=%h want=%h", cyc, cpu_rdata, exp_rdata); end
      end
      total++; if (wbuf_count !== 3'(wq.size())) begin bad++; $display("[TB] FAIL rnd_count c%0d got=%0d want=%0d", cyc, wbuf_count, wq.size()); end
      if (exp_we) begin
        ref_mem[wq[0].addr] = wq[0].data;
        void'(wq.pop_front());
      end
      if (req && exp_ready) begin
        if (we) begin
          e.addr = a;
          e.data = d;
          wq.push_back(e);
        end else if (hit) begin
          rv_at = cyc + 1;
          exp_rdata = hdata;
        end else begin
          rv_at = cyc + RD_LAT + 1;
          busy_until = cyc + RD_LAT + 1;
          exp_rdata = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
        end
      end
      cyc++;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_wbuf_full();
    test_forward();
    test_read_miss();
    test_drain_priority();
    test_reset_rd_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
